cc_serializer: RTL and testbench

- Read-response side of the cache controller. It returns one 64-byte cache line per accepted read request on the interconnect R channel.
- Each line goes out as a critical-word-first wrapping burst of 64-bit beats.
- Responses leave in request order. The hit flag FIFO selects the source of the next line: the hit data FIFO (hit) or the memory fill path (miss).
- Sits downstream of the decoder/tag-compare stages and drives inct_r* toward the interconnect.

---
 rtl/cc_pkg.sv | 19 +
 rtl/cc_serializer.sv | 113 +++++++++++
 tb/tb_cc_serializer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared constants and types for the cache controller read-response path.
package cc_pkg;

   localparam int LINE_W     = 512;
   localparam int DATA_W     = 64;
   localparam int BEATS      = LINE_W / DATA_W;
   localparam int BEAT_IDX_W = $clog2(BEATS);

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   // A cache line viewed as an array of R-channel beats.
   typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

endpackage

// File: rtl/cc_serializer.sv
// Read-response serializer: turns each hit or fill line into a
// critical-word-first wrapping burst on the interconnect R channel,
// in request order as dictated by the hit flag FIFO.
module cc_serializer
   import cc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              hit_flag_fifo_empty_i,
   input  logic              hit_flag_fifo_rdata_i,
   output logic              hit_flag_fifo_rden_o,
   input  logic              hit_data_fifo_empty_i,
   input  logic [LINE_W-1:0] hit_data_fifo_rdata_i,
   input  logic [5:0]        hit_data_fifo_offset_i,
   output logic              hit_data_fifo_rden_o,
   input  logic              miss_data_valid_i,
   input  logic [LINE_W-1:0] miss_data_i,
   input  logic [5:0]        miss_offset_i,
   output logic              miss_data_ready_o,
   output logic [DATA_W-1:0] inct_rdata_o,
   output logic [1:0]        inct_rresp_o,
   output logic              inct_rlast_o,
   output logic              inct_rvalid_o,
   input  logic              inct_rready_i
);

   localparam logic [BEAT_IDX_W-1:0] LAST_CNT = BEAT_IDX_W'(BEATS - 1);

   state_t                state_q, state_d;
   line_t                 line_q;
   logic [BEAT_IDX_W-1:0] beat_idx_q;
   logic [BEAT_IDX_W-1:0] beat_cnt_q;

   logic                  sel_hit;
   logic                  src_ok;
   logic                  send;
   logic                  last_hs;
   logic                  load;
   line_t                 src_line;
   logic [BEAT_IDX_W-1:0] src_beat;

   // Byte-within-beat offset bits never matter: beats are always full width.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{hit_data_fifo_offset_i[2:0], miss_offset_i[2:0]};

   // The flag at the FIFO head decides which source owns the next line; a
   // flag whose data is not there yet blocks everything behind it, which
   // is what keeps responses in order.
   assign sel_hit = hit_flag_fifo_rdata_i;
   assign src_ok  = !hit_flag_fifo_empty_i &&
                    (sel_hit ? !hit_data_fifo_empty_i : miss_data_valid_i);
   assign send    = (state_q == S_SEND);
   assign last_hs = send && inct_rready_i && (beat_cnt_q == LAST_CNT);
   // Held off during reset so nothing is popped that the line register drops.
   assign load    = !rst && src_ok && ((state_q == S_IDLE) || last_hs);

   // Source mux: selected line and its critical-word beat index.
   always_comb begin
      src_line = miss_data_i;
      src_beat = miss_offset_i[5:3];
      if (sel_hit) begin
         src_line = hit_data_fifo_rdata_i;
         src_beat = hit_data_fifo_offset_i[5:3];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: a last-beat handshake chains straight into the next
   // line when one is ready, otherwise drops back to idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (src_ok)            state_d = S_SEND;
         S_SEND:  if (last_hs && !src_ok) state_d = S_IDLE;
         default:                        state_d = S_IDLE;
      endcase
   end

   // FSM outputs: pops are one-cycle pulses on load, R channel driven from
   // the latched line so it holds steady under backpressure.
   always_comb begin
      hit_flag_fifo_rden_o = load;
      hit_data_fifo_rden_o = load && sel_hit;
      miss_data_ready_o    = load && !sel_hit;
      inct_rvalid_o        = send;
      inct_rlast_o         = send && (beat_cnt_q == LAST_CNT);
      inct_rdata_o         = send ? line_q[beat_idx_q] : '0;
      inct_rresp_o         = RESP_OKAY;
   end

   // Line register and beat counters: load resets the burst at the
   // critical word, each handshake advances with natural wrap at BEATS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q     <= '0;
         beat_idx_q <= '0;
         beat_cnt_q <= '0;
      end else if (load) begin
         line_q     <= src_line;
         beat_idx_q <= src_beat;
         beat_cnt_q <= '0;
      end else if (send && inct_rready_i) begin
         beat_idx_q <= beat_idx_q + 1'b1;
         beat_cnt_q <= beat_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_cc_serializer.sv
// Bench for cc_serializer: FIFO/fill-path models feed randomized lines,
// a queue of expected beats (built from request order and offset) is the
// reference, and per-cycle checks cover pops, latency and hold stability.
module tb_cc_serializer;
   import cc_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              hit_flag_fifo_empty_i;
   logic              hit_flag_fifo_rdata_i;
   logic              hit_flag_fifo_rden_o;
   logic              hit_data_fifo_empty_i;
   logic [LINE_W-1:0] hit_data_fifo_rdata_i;
   logic [5:0]        hit_data_fifo_offset_i;
   logic              hit_data_fifo_rden_o;
   logic              miss_data_valid_i;
   logic [LINE_W-1:0] miss_data_i;
   logic [5:0]        miss_offset_i;
   logic              miss_data_ready_o;
   logic [DATA_W-1:0] inct_rdata_o;
   logic [1:0]        inct_rresp_o;
   logic              inct_rlast_o;
   logic              inct_rvalid_o;
   logic              inct_rready_i;

   always #5 clk = ~clk;

   cc_serializer dut (
      .clk                    (clk),
      .rst                    (rst),
      .hit_flag_fifo_empty_i  (hit_flag_fifo_empty_i),
      .hit_flag_fifo_rdata_i  (hit_flag_fifo_rdata_i),
      .hit_flag_fifo_rden_o   (hit_flag_fifo_rden_o),
      .hit_data_fifo_empty_i  (hit_data_fifo_empty_i),
      .hit_data_fifo_rdata_i  (hit_data_fifo_rdata_i),
      .hit_data_fifo_offset_i (hit_data_fifo_offset_i),
      .hit_data_fifo_rden_o   (hit_data_fifo_rden_o),
      .miss_data_valid_i      (miss_data_valid_i),
      .miss_data_i            (miss_data_i),
      .miss_offset_i          (miss_offset_i),
      .miss_data_ready_o      (miss_data_ready_o),
      .inct_rdata_o           (inct_rdata_o),
      .inct_rresp_o           (inct_rresp_o),
      .inct_rlast_o           (inct_rlast_o),
      .inct_rvalid_o          (inct_rvalid_o),
      .inct_rready_i          (inct_rready_i)
   );

   typedef struct { bit hit; int t; } flag_t;
   typedef struct { logic [LINE_W-1:0] line; logic [5:0] off; int t; } line_ent_t;
   typedef struct { logic [DATA_W-1:0] d; bit last; } beat_t;

   flag_t     flag_q[$];
   line_ent_t hit_q[$];
   line_ent_t miss_q[$];
   beat_t     exp_q[$];

   int cyc, n_chk, n_err;
   int n_flag_pop, n_hit_pop, n_miss_pop, n_vld, n_last, n_beats, first_vld, last_vld;
   bit rr_rand, hold_pend, load_pend;
   logic [DATA_W-1:0] hold_d;
   logic              hold_l;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit flag_vis();
      if (flag_q.size() == 0) return 1'b0;
      return flag_q[0].t <= cyc;
   endfunction

   function automatic bit hit_vis();
      if (hit_q.size() == 0) return 1'b0;
      return hit_q[0].t <= cyc;
   endfunction

   function automatic bit miss_vis();
      if (miss_q.size() == 0) return 1'b0;
      return miss_q[0].t <= cyc;
   endfunction

   // Present the heads of the modelled FIFOs / fill path to the DUT.
   task automatic drive();
      hit_flag_fifo_empty_i  = !flag_vis();
      hit_flag_fifo_rdata_i  = 1'b0;
      if (flag_vis()) hit_flag_fifo_rdata_i = flag_q[0].hit;
      hit_data_fifo_empty_i  = !hit_vis();
      hit_data_fifo_rdata_i  = '0;
      hit_data_fifo_offset_i = '0;
      if (hit_vis()) begin
         hit_data_fifo_rdata_i  = hit_q[0].line;
         hit_data_fifo_offset_i = hit_q[0].off;
      end
      miss_data_valid_i = miss_vis();
      miss_data_i       = '0;
      miss_offset_i     = '0;
      if (miss_vis()) begin
         miss_data_i   = miss_q[0].line;
         miss_offset_i = miss_q[0].off;
      end
   endtask

   // Queue one request; expected beats follow from offset alone.
   task automatic push_req(input bit hit, input int fdly, input int ddly, input logic [5:0] off);
      line_ent_t e;
      flag_t     f;
      beat_t     b;
      int        base;
      for (int w = 0; w < LINE_W / 32; w++) e.line[w*32 +: 32] = $urandom();
      e.off = off;
      e.t   = cyc + ddly;
      f.hit = hit;
      f.t   = cyc + fdly;
      flag_q.push_back(f);
      if (hit) hit_q.push_back(e);
      else     miss_q.push_back(e);
      base = int'(off) / 8;
      for (int k = 0; k < BEATS; k++) begin
         b.d    = e.line[((base + k) % BEATS) * DATA_W +: DATA_W];
         b.last = (k == BEATS - 1);
         exp_q.push_back(b);
      end
      drive();
   endtask

   task automatic clr_stats();
      n_flag_pop = 0; n_hit_pop = 0; n_miss_pop = 0;
      n_vld = 0; n_last = 0; n_beats = 0; first_vld = -1; last_vld = -1;
   endtask

   // One clock: check at negedge, apply pops/new inputs just after posedge.
   task automatic tick();
      bit    pf, ph, pm, head_hit, src, exp_load;
      beat_t b;
      @(negedge clk);
      pf = hit_flag_fifo_rden_o;
      ph = hit_data_fifo_rden_o;
      pm = miss_data_ready_o;
      if (hold_pend) begin
         chk("hold_vld", inct_rvalid_o, 1'b1);
         chk("hold_data", inct_rdata_o, hold_d);
         chk("hold_last", inct_rlast_o, hold_l);
      end
      if (load_pend) chk("load_lat", inct_rvalid_o, 1'b1);
      head_hit = 1'b0;
      src      = 1'b0;
      if (flag_vis()) begin
         head_hit = flag_q[0].hit;
         src      = head_hit ? hit_vis() : miss_vis();
      end
      exp_load = src && (!inct_rvalid_o || (inct_rready_i && inct_rlast_o));
      chk("flag_rden", pf, exp_load);
      chk("hit_rden", ph, exp_load && head_hit);
      chk("miss_ready", pm, exp_load && !head_hit);
      if (inct_rvalid_o) begin
         n_vld++;
         if (first_vld < 0) first_vld = cyc;
         last_vld = cyc;
      end
      if (inct_rvalid_o && inct_rready_i) begin
         n_beats++;
         chk("rresp", inct_rresp_o, RESP_OKAY);
         chk("beat_expected", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("rdata", inct_rdata_o, b.d);
            chk("rlast", inct_rlast_o, b.last);
            if (b.last) n_last++;
         end
      end
      hold_pend = inct_rvalid_o && !inct_rready_i;
      hold_d    = inct_rdata_o;
      hold_l    = inct_rlast_o;
      load_pend = pf;
      @(posedge clk);
      #1;
      cyc++;
      if (pf && flag_q.size() != 0) begin void'(flag_q.pop_front()); n_flag_pop++; end
      if (ph && hit_q.size() != 0)  begin void'(hit_q.pop_front());  n_hit_pop++;  end
      if (pm && miss_q.size() != 0) begin void'(miss_q.pop_front()); n_miss_pop++; end
      inct_rready_i = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      drive();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || flag_q.size() != 0 || inct_rvalid_o) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", 64'(n < budget), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b1;
      rr_rand = 1'b0;
      inct_rready_i = 1'b1;
      cyc = 0; n_chk = 0; n_err = 0;
      hold_pend = 1'b0; load_pend = 1'b0;
      clr_stats();
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", inct_rvalid_o, 1'b0);
      chk("rst_rlast", inct_rlast_o, 1'b0);
      chk("rst_rdata", inct_rdata_o, '0);
      chk("rst_rresp", inct_rresp_o, 2'b00);
      chk("rst_flag_rden", hit_flag_fifo_rden_o, 1'b0);
      chk("rst_hit_rden", hit_data_fifo_rden_o, 1'b0);
      chk("rst_miss_ready", miss_data_ready_o, 1'b0);
      rst = 1'b0;
      tick();

      // single hit, offset 0
      clr_stats(); c0 = cyc;
      push_req(1'b1, 0, 0, 6'h00);
      drain(60);
      chk("t1_flag_pops", n_flag_pop, 1);
      chk("t1_hit_pops", n_hit_pop, 1);
      chk("t1_miss_pops", n_miss_pop, 0);
      chk("t1_first_beat", first_vld - c0, 1);
      chk("t1_vld_cycles", n_vld, 8);
      chk("t1_last_cnt", n_last, 1);

      // single miss, offset 0x28, fill 5 cycles after flag
      clr_stats(); c0 = cyc;
      push_req(1'b0, 0, 5, 6'h28);
      drain(60);
      chk("t2_miss_pops", n_miss_pop, 1);
      chk("t2_hit_pops", n_hit_pop, 0);
      chk("t2_first_beat", first_vld - c0, 6);
      chk("t2_vld_cycles", n_vld, 8);

      // back-to-back hit, miss, hit
      clr_stats(); c0 = cyc;
      push_req(1'b1, 0, 0, 6'($urandom_range(0, 63)));
      push_req(1'b0, 0, 0, 6'($urandom_range(0, 63)));
      push_req(1'b1, 0, 0, 6'($urandom_range(0, 63)));
      drain(100);
      chk("t3_vld_cycles", n_vld, 24);
      chk("t3_span", last_vld - first_vld + 1, 24);
      chk("t3_last_cnt", n_last, 3);
      chk("t3_flag_pops", n_flag_pop, 3);

      // miss then hit, hit data early, fill 10 cycles late
      clr_stats(); c0 = cyc;
      push_req(1'b0, 0, 10, 6'h10);
      push_req(1'b1, 0, 0, 6'h38);
      drain(100);
      chk("t4_first_beat", first_vld - c0, 11);
      chk("t4_span", last_vld - first_vld + 1, 16);

      // fill present before its flag, offset 0x3F (low bits ignored)
      clr_stats(); c0 = cyc;
      push_req(1'b0, 4, 0, 6'h3F);
      drain(60);
      chk("t5_first_beat", first_vld - c0, 5);
      chk("t5_miss_pops", n_miss_pop, 1);

      // random traffic under random backpressure
      clr_stats();
      rr_rand = 1'b1;
      for (int i = 0; i < 8; i++)
         push_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 12),
                  6'($urandom_range(0, 63)));
      drain(2000);
      rr_rand = 1'b0;
      chk("t6_beats", n_beats, 64);
      chk("t6_last_cnt", n_last, 8);
      tick();

      // reset during beat 3 of a burst, with another line queued
      clr_stats();
      push_req(1'b1, 0, 0, 6'($urandom_range(0, 63)));
      push_req(1'b0, 0, 0, 6'($urandom_range(0, 63)));
      c0 = 0;
      while (n_beats < 3 && c0 < 40) begin tick(); c0++; end
      chk("t7_reach_beat3", 64'(c0 < 40), 1);
      chk("t7_pre_vld", inct_rvalid_o, 1'b1);
      rst = 1'b1;
      #1;
      chk("t7_async_vld", inct_rvalid_o, 1'b0);
      chk("t7_async_last", inct_rlast_o, 1'b0);
      chk("t7_async_data", inct_rdata_o, '0);
      chk("t7_rst_flag_rden", hit_flag_fifo_rden_o, 1'b0);
      chk("t7_rst_miss_ready", miss_data_ready_o, 1'b0);
      repeat (5) void'(exp_q.pop_front());
      hold_pend = 1'b0;
      load_pend = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      chk("t7_rst_vld_hold", inct_rvalid_o, 1'b0);
      rst = 1'b0;
      drive();
      clr_stats(); c0 = cyc;
      drain(60);
      chk("t7_miss_pops", n_miss_pop, 1);
      chk("t7_first_beat", first_vld - c0, 1);
      chk("t7_beats", n_beats, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
